tdc_thermo_stim_gen: RTL and testbench

- Counterpart to the TDC ones-counter slices: converts binary counts back into thermometer-coded tap words (ones filled from LSB).
- Drives the TDC encoder datapath during self-test and calibration instead of the real delay line.
- Two modes:
  - DIRECT: each count supplied by the test controller becomes one thermometer word.
  - SWEEP: autonomous ramp 0..TAP_WIDTH, each code held for a programmable number of accepted beats, with wrap.

---
 rtl/tdc_pkg.sv | 19 +
 rtl/tdc_thermo_stim_gen_count_to_thermo.sv | 27 ++
 rtl/tdc_thermo_stim_gen.sv | 168 ++++++++++++++++
 tb/tb_tdc_thermo_stim_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared TDC definitions: default tap/count widths shared with the ones-counter
// slices, the stimulus generator FSM state type and the mode encodings.
package tdc_pkg;

  localparam int unsigned TDC_TAP_WIDTH  = 6;
  localparam int unsigned TDC_CNT_WIDTH  = 3;
  localparam int unsigned TDC_HOLD_WIDTH = 4;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SWEEP  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SWEEP  = 2'd2,
    ST_DRAIN  = 2'd3
  } tdc_state_e;

endpackage

// File: rtl/tdc_thermo_stim_gen_count_to_thermo.sv
// count_to_thermo: combinational binary count to thermometer word converter.
// Ones fill from the LSB; counts above TAP_WIDTH saturate and raise sat.
// Ports:
//   count   binary input count
//   thermo  thermometer word, thermo[k] = (k < n)
//   n       encoded count after saturation, min(count, TAP_WIDTH)
//   sat     count was larger than TAP_WIDTH
module count_to_thermo #(
  parameter int unsigned TAP_WIDTH = 6,
  parameter int unsigned CNT_WIDTH = 3
) (
  input  logic [CNT_WIDTH-1:0] count,
  output logic [TAP_WIDTH-1:0] thermo,
  output logic [CNT_WIDTH-1:0] n,
  output logic                 sat
);

  always_comb begin
    sat    = (32'(count) > TAP_WIDTH);
    n      = sat ? CNT_WIDTH'(TAP_WIDTH) : count;
    thermo = '0;
    for (int unsigned k = 0; k < TAP_WIDTH; k++) begin
      thermo[k] = (k < 32'(n));
    end
  end

endmodule

// File: rtl/tdc_thermo_stim_gen.sv
// tdc_thermo_stim_gen: thermometer tap-word stimulus for the TDC encoder path.
// DIRECT mode encodes each accepted i_Count; SWEEP mode ramps 0..TAP_WIDTH,
// holding each code for a programmable number of accepted beats, with wrap.
// Ports:
//   i_Clk, i_Rst              clock, asynchronous active-high reset
//   i_Start, i_Mode, i_Stop   control pulses; mode sampled on start in IDLE
//   i_Hold                    sweep beats per code (0 behaves as 1)
//   i_Count, i_CountValid,
//   o_CountReady              DIRECT-mode count input handshake
//   o_Thermo, o_ThermoCount,
//   o_Sat, o_Valid, i_Ready   registered output beat and its handshake
//   o_Busy                    FSM not in IDLE
//   o_Wrap                    pulse with the code-0 load that ends a sweep pass
module tdc_thermo_stim_gen
  import tdc_pkg::*;
#(
  parameter int unsigned TAP_WIDTH  = TDC_TAP_WIDTH,
  parameter int unsigned CNT_WIDTH  = TDC_CNT_WIDTH,
  parameter int unsigned HOLD_WIDTH = TDC_HOLD_WIDTH
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Start,
  input  logic                  i_Mode,
  input  logic                  i_Stop,
  input  logic [HOLD_WIDTH-1:0] i_Hold,
  input  logic [CNT_WIDTH-1:0]  i_Count,
  input  logic                  i_CountValid,
  output logic                  o_CountReady,
  output logic [TAP_WIDTH-1:0]  o_Thermo,
  output logic [CNT_WIDTH-1:0]  o_ThermoCount,
  output logic                  o_Valid,
  input  logic                  i_Ready,
  output logic                  o_Sat,
  output logic                  o_Busy,
  output logic                  o_Wrap
);

  tdc_state_e            state;
  logic                  valid;
  logic [TAP_WIDTH-1:0]  thermo;
  logic [CNT_WIDTH-1:0]  thermo_count;
  logic                  sat;
  logic                  wrap;
  logic                  wrap_next;
  logic [CNT_WIDTH-1:0]  sweep_code;
  logic [HOLD_WIDTH-1:0] hold_cnt;
  logic [HOLD_WIDTH-1:0] hold_cfg;

  logic                  out_free;
  logic                  count_ready;
  logic                  direct_accept;
  logic                  sweep_load;
  logic [CNT_WIDTH-1:0]  enc_count;
  logic [TAP_WIDTH-1:0]  enc_thermo;
  logic [CNT_WIDTH-1:0]  enc_n;
  logic                  enc_sat;

  assign out_free      = !valid || i_Ready;
  assign count_ready   = (state == ST_DIRECT) && out_free;
  assign direct_accept = count_ready && i_CountValid;
  assign sweep_load    = (state == ST_SWEEP) && out_free && !i_Stop;
  assign enc_count     = (state == ST_SWEEP) ? sweep_code : i_Count;

  count_to_thermo #(
    .TAP_WIDTH (TAP_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_enc (
    .count  (enc_count),
    .thermo (enc_thermo),
    .n      (enc_n),
    .sat    (enc_sat)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state        <= ST_IDLE;
      valid        <= 1'b0;
      thermo       <= '0;
      thermo_count <= '0;
      sat          <= 1'b0;
      wrap         <= 1'b0;
      wrap_next    <= 1'b0;
      sweep_code   <= '0;
      hold_cnt     <= '0;
      hold_cfg     <= '0;
    end else begin
      wrap <= 1'b0;
      case (state)
        ST_IDLE: begin
          valid <= 1'b0;
          if (i_Start) begin
            state      <= (i_Mode == MODE_SWEEP) ? ST_SWEEP : ST_DIRECT;
            hold_cfg   <= (i_Hold == '0) ? HOLD_WIDTH'(1) : i_Hold;
            sweep_code <= '0;
            hold_cnt   <= '0;
            wrap_next  <= 1'b0;
          end
        end

        ST_DIRECT: begin
          if (direct_accept) begin
            valid        <= 1'b1;
            thermo       <= enc_thermo;
            thermo_count <= enc_n;
            sat          <= enc_sat;
          end else if (i_Ready) begin
            valid <= 1'b0;
          end
          // An accept coinciding with stop is still loaded, then drained.
          if (i_Stop) begin
            state <= (valid || direct_accept) ? ST_DRAIN : ST_IDLE;
          end
        end

        ST_SWEEP: begin
          // Only loads when the previous beat has gone, so counting loads is
          // the same as counting accepted beats and a stall freezes the ramp.
          if (sweep_load) begin
            valid        <= 1'b1;
            thermo       <= enc_thermo;
            thermo_count <= enc_n;
            sat          <= enc_sat;
            wrap         <= wrap_next;
            wrap_next    <= 1'b0;
            if (hold_cnt == HOLD_WIDTH'(hold_cfg - 1'b1)) begin
              hold_cnt <= '0;
              if (sweep_code == CNT_WIDTH'(TAP_WIDTH)) begin
                sweep_code <= '0;
                wrap_next  <= 1'b1;
              end else begin
                sweep_code <= sweep_code + 1'b1;
              end
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end else if (i_Ready) begin
            valid <= 1'b0;
          end
          if (i_Stop) begin
            state <= valid ? ST_DRAIN : ST_IDLE;
          end
        end

        ST_DRAIN: begin
          if (out_free) begin
            valid <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_CountReady  = count_ready;
  assign o_Thermo      = thermo;
  assign o_ThermoCount = thermo_count;
  assign o_Valid       = valid;
  assign o_Sat         = sat;
  assign o_Wrap        = wrap;
  assign o_Busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_tdc_thermo_stim_gen.sv
module tb_tdc_thermo_stim_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic       mode;
  logic       stop;
  logic [3:0] hold;
  logic [2:0] count;
  logic       count_valid;
  logic       count_ready;
  logic [5:0] thermo;
  logic [2:0] thermo_count;
  logic       valid;
  logic       ready;
  logic       sat;
  logic       busy;
  logic       wrap;

  int n_asserts = 0;
  int n_fail    = 0;

  tdc_thermo_stim_gen #(
    .TAP_WIDTH  (6),
    .CNT_WIDTH  (3),
    .HOLD_WIDTH (4)
  ) dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_Start       (start),
    .i_Mode        (mode),
    .i_Stop        (stop),
    .i_Hold        (hold),
    .i_Count       (count),
    .i_CountValid  (count_valid),
    .o_CountReady  (count_ready),
    .o_Thermo      (thermo),
    .o_ThermoCount (thermo_count),
    .o_Valid       (valid),
    .i_Ready       (ready),
    .o_Sat         (sat),
    .o_Busy        (busy),
    .o_Wrap        (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoding: n = min(c, 6) ones filled from the LSB.
  function automatic logic [5:0] therm(input int c);
    int n;
    n = (c > 6) ? 6 : c;
    return 6'((1 << n) - 1);
  endfunction

  function automatic int clamp(input int c);
    return (c > 6) ? 6 : c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sweep from IDLE: beat k (0-based, counted in accepted beats) carries
  // code (k / h) % 7 and wraps when k is a nonzero multiple of 7*h.
  task automatic run_sweep(input int h_in, input int beats, input bit rnd, output int last_code);
    int  h;
    int  k;
    bit  pend;
    bit  load_next;
    int  code;
    h         = (h_in == 0) ? 1 : h_in;
    k         = 0;
    pend      = 1'b0;
    last_code = 0;
    hold  = 4'(h_in);
    mode  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sw_entry_busy", busy, 1);
    chk("sw_entry_valid", valid, 0);
    chk("sw_cready", count_ready, 0);
    for (int cyc = 0; cyc < 600; cyc++) begin
      ready     = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      load_next = !pend || ready;
      if (pend && ready) k++;
      tick();
      pend = 1'b1;
      code = (k / h) % 7;
      last_code = code;
      chk("sw_valid", valid, 1);
      chk("sw_code", thermo_count, code);
      chk("sw_thermo", thermo, therm(code));
      chk("sw_sat", sat, 0);
      chk("sw_wrap", wrap, (load_next && k > 0 && (k % (7 * h)) == 0));
      if (k >= beats - 1) break;
    end
    chk("sw_beats_reached", k, beats - 1);
  endtask

  int  cnts [4];
  bit  pend;
  int  pend_c;
  bit  exp_cr;
  int  last;

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; stop = 1'b0; hold = '0;
    count = '0; count_valid = 1'b0; ready = 1'b1;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_thermo", thermo, 0);
    chk("rst_tcount", thermo_count, 0);
    chk("rst_sat", sat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_cready", count_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Start and stop together in IDLE: start wins, DIRECT entered.
    start = 1'b1; stop = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 1);
    chk("ss_direct_cready", count_ready, 1);
    // Start with SWEEP mode while in DIRECT is ignored.
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_direct_cready", count_ready, 1);
    tick();
    chk("start_in_direct_valid", valid, 0);
    chk("start_in_direct_cready2", count_ready, 1);

    // Back-to-back DIRECT counts with saturation.
    cnts = '{0, 3, 6, 7};
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      count = 3'(cnts[i]); count_valid = 1'b1;
      #1;
      chk("b2b_cready", count_ready, 1);
      tick();
      chk("b2b_valid", valid, 1);
      chk("b2b_thermo", thermo, therm(cnts[i]));
      chk("b2b_tcount", thermo_count, clamp(cnts[i]));
      chk("b2b_sat", sat, (cnts[i] > 6));
    end
    count_valid = 1'b0;
    tick();
    chk("b2b_idle_valid", valid, 0);

    // Stall after count 2: word held, count 4 waits for the release.
    count = 3'd2; count_valid = 1'b1;
    tick();
    chk("stall_thermo0", thermo, 6'b000011);
    ready = 1'b0; count = 3'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_cready", count_ready, 0);
      tick();
      chk("stall_valid", valid, 1);
      chk("stall_thermo", thermo, 6'b000011);
      chk("stall_tcount", thermo_count, 2);
    end
    ready = 1'b1;
    #1;
    chk("stall_release_cready", count_ready, 1);
    tick();
    chk("stall_next_thermo", thermo, 6'b001111);
    chk("stall_next_tcount", thermo_count, 4);
    count_valid = 1'b0;
    tick();
    chk("stall_end_valid", valid, 0);

    // Random DIRECT traffic against a one-entry transaction model.
    pend = 1'b0; pend_c = 0;
    for (int i = 0; i < 80; i++) begin
      count       = 3'($urandom_range(0, 7));
      count_valid = 1'($urandom_range(0, 1));
      ready       = ($urandom_range(0, 2) != 0);
      #1;
      exp_cr = !pend || ready;
      chk("rnd_cready", count_ready, exp_cr);
      if (pend && ready) pend = 1'b0;
      if (count_valid && exp_cr) begin
        pend   = 1'b1;
        pend_c = int'(count);
      end
      tick();
      chk("rnd_valid", valid, pend);
      if (pend) begin
        chk("rnd_thermo", thermo, therm(pend_c));
        chk("rnd_tcount", thermo_count, clamp(pend_c));
        chk("rnd_sat", sat, (pend_c > 6));
      end
    end
    count_valid = 1'b0; ready = 1'b1;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("direct_stop_busy", busy, 0);
    chk("direct_stop_valid", valid, 0);

    // SWEEP Hold=2: wrap on the 15th beat.
    run_sweep(2, 15, 1'b0, last);
    ready = 1'b1; stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("sw2_stop_valid", valid, 0);
    chk("sw2_stop_wrap", wrap, 0);
    tick();
    chk("sw2_stop_busy", busy, 0);

    // SWEEP Hold=0 behaves as one beat per code.
    run_sweep(0, 9, 1'b0, last);
    ready = 1'b1; stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk("sw0_stop_busy", busy, 0);

    // Random hold and back-pressure, then stop while stalled.
    run_sweep($urandom_range(1, 3), 30, 1'b1, last);
    ready = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drain_busy", busy, 1);
      chk("drain_valid", valid, 1);
      chk("drain_tcount", thermo_count, last);
      chk("drain_thermo", thermo, therm(last));
      tick();
    end
    ready = 1'b1;
    tick();
    chk("drain_done_valid", valid, 0);
    chk("drain_done_busy", busy, 0);

    // Reset one beat before a wrap: no wrap pulse, everything cleared.
    run_sweep(1, 7, 1'b0, last);
    chk("prerst_code", thermo_count, 6);
    rst = 1'b1;
    #1;
    chk("midrst_valid", valid, 0);
    chk("midrst_thermo", thermo, 0);
    chk("midrst_busy", busy, 0);
    tick();
    chk("midrst_wrap", wrap, 0);
    chk("midrst_tcount", thermo_count, 0);
    chk("midrst_sat", sat, 0);
    rst = 1'b0;
    tick();
    chk("postrst_wrap", wrap, 0);
    chk("postrst_busy", busy, 0);
    chk("postrst_valid", valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
